modo1_avaliador_nota: RTL and testbench
=======================================

Name: modo1_avaliador_nota

Overview:
- Upstream stage of the mode-1 control unit.
- Synchronizes and debounces the 12 piano keys and generates the `nota_feita` level.
- Latches the played note and measures its held duration in metronome ticks.
- At a confirmed release, produces `nota_correta` and `tempo_correto`. The control unit reads these in its compare state, one cycle after `nota_feita` falls.

Parameters:
- DEBOUNCE, 50000, consecutive stable cycles required to confirm a press or release (1 ms at 50 MHz).
- TOL, 1, allowed ±tick deviation between measured and expected duration.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- habilita  in  1  player's turn; a new press is accepted only while high.
- limpa  in  1  synchronous clear of measurement and results.
- teclas  in  12  raw key inputs; bit i = note i+1.
- tick  in  1  one-cycle pulse per sixteenth-beat from the metronome.
- nota_esperada  in  4  expected note code from memory, 1..12.
- duracao_esperada  in  4  expected duration in ticks.
- nota_feita  out  1  high while a confirmed key is held.
- nota_tocada  out  4  latched code of the last confirmed key; 0 = none.
- nota_correta  out  1  registered note-compare result.
- tempo_correto  out  1  registered duration-compare result.
- duracao_medida  out  5  ticks counted during the last or current press.
- db_estado  out  3  current state, for debug.

Behaviour:
- **Input synchronization**
  - `teclas` passes through 2 flip-flops before any use. The synchronized value is called `sinc`.
  - `sinc` is one-hot when exactly one bit is set.
- **Reset** (reset=0, asynchronous)
  - State goes to OCIOSO.
  - All outputs become 0; the debounce and duration counters become 0.
- **limpa** (synchronous)
  - Highest priority.
  - Next state is OCIOSO; counters, `nota_tocada`, `nota_correta`, `tempo_correto` and `duracao_medida` are cleared to 0.
- **States**
  - OCIOSO=0
    - Leaves only when habilita=1 and `sinc` is one-hot. It then goes to ESTABILIZA, captures `sinc` as the candidate and sets the debounce counter to 1.
    - A zero or multi-key `sinc` keeps it in OCIOSO.
  - ESTABILIZA=1
    - If `sinc` equals the candidate, the counter increments.
    - If `sinc` differs but is one-hot, it becomes the new candidate and the counter goes to 1.
    - If `sinc` is zero or multi-key, go back to OCIOSO.
    - When the counter reaches DEBOUNCE, go to PRESSIONADA. On that edge:
      - `nota_feita` goes to 1;
      - `nota_tocada` gets the index of the candidate's set bit plus 1;
      - `duracao_medida` is cleared to 0;
      - `nota_correta` and `tempo_correto` are cleared to 0.
  - PRESSIONADA=2
    - Each tick adds 1 to `duracao_medida`, saturating at 31.
    - If `sinc` differs from the latched one-hot, go to SOLTANDO with the debounce counter at 1.
  - SOLTANDO=3
    - `nota_feita` stays 1 and ticks keep counting.
    - If `sinc` equals the latched one-hot again, go back to PRESSIONADA (a bounce); the duration is kept.
    - Otherwise the counter increments. When it reaches DEBOUNCE, go to RESULTADO. On that same edge:
      - `nota_feita` goes to 0;
      - `nota_correta` = (`nota_tocada` == `nota_esperada`);
      - `tempo_correto` = (`duracao_medida` + TOL ≥ `duracao_esperada`) AND (`duracao_medida` ≤ `duracao_esperada` + TOL). Compute in 6-bit unsigned arithmetic; no underflow.
  - RESULTADO=4
    - Results, `nota_tocada` and `duracao_medida` are held.
    - Go to OCIOSO only when `sinc` is all zeros, so a chord or slide during release cannot start a new press.
- **Results validity:** results are valid from the cycle `nota_feita` falls until the next confirmed press or limpa.
- **habilita:** dropping habilita does not abort a press already in progress.
- **Simultaneous events:** a tick in the same cycle as the confirming edge (entry into PRESSIONADA) is not counted. A tick in the same cycle as the release-confirming edge is counted before the comparison.

Test Plan (DEBOUNCE=4, TOL=1):
- Reset low mid-press → all outputs 0 and db_estado=0 immediately, without waiting for a clock edge.
- habilita=1, teclas=0x004 clean for 20 cycles with 5 ticks, then teclas=0, nota_esperada=3, duracao_esperada=5 → `nota_feita` rises 6 cycles after the press (2 sync + 4 debounce). After release: `nota_tocada`=3, `duracao_medida`=5, `nota_correta`=1, `tempo_correto`=1.
- Same press with duracao_esperada=8 and 5 ticks → `tempo_correto`=0. With duracao_esperada=0 and 1 tick → `tempo_correto`=1.
- A 2-cycle release glitch inside the press → `nota_feita` never falls and the tick count continues.
- teclas=0x011 (two keys) → stays in OCIOSO, `nota_feita`=0. With habilita=0, a clean single-key press is ignored.
- limpa during PRESSIONADA → next cycle OCIOSO, all results 0. After release, keys held at 0x800 → no new press until all keys read 0.

Source files
------------

// File: rtl/modo1_avaliador_nota.sv
// Mode-1 note evaluator: synchronizes and debounces the piano keys, latches the played note,
// measures its held duration in metronome ticks and registers the note/duration comparison.
module modo1_avaliador_nota #(
  parameter int unsigned DEBOUNCE = 50000,
  parameter int unsigned TOL      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        habilita,
  input  logic        limpa,
  input  logic [11:0] teclas,
  input  logic        tick,
  input  logic [3:0]  nota_esperada,
  input  logic [3:0]  duracao_esperada,
  output logic        nota_feita,
  output logic [3:0]  nota_tocada,
  output logic        nota_correta,
  output logic        tempo_correto,
  output logic [4:0]  duracao_medida,
  output logic [2:0]  db_estado
);

  localparam int unsigned CntW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);
  localparam logic [5:0]      TolV    = 6'(TOL);

  typedef enum logic [2:0] {
    Ocioso      = 3'd0,
    Estabiliza  = 3'd1,
    Pressionada = 3'd2,
    Soltando    = 3'd3,
    Resultado   = 3'd4
  } estado_e;

  estado_e         estado_q, estado_d;
  logic [11:0]     sinc_meta_q, sinc_q;
  logic [11:0]     cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      tocada_q, tocada_d;
  logic [4:0]      dur_q, dur_d;
  logic            correta_q, correta_d;
  logic            tempo_q, tempo_d;

  logic            sinc_oh;
  logic [3:0]      cand_idx;
  logic [4:0]      dur_inc;
  logic [5:0]      dur_ext, esp_ext;
  logic            tempo_ok;

  // Two-flop synchronizer on the raw keys.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc_meta_q <= '0;
      sinc_q      <= '0;
    end else begin
      sinc_meta_q <= teclas;
      sinc_q      <= sinc_meta_q;
    end
  end

  assign sinc_oh = (sinc_q != 12'd0) && ((sinc_q & (sinc_q - 12'd1)) == 12'd0);

  always_comb begin
    cand_idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (cand_q[i]) cand_idx = 4'(i + 1);
    end
  end

  // Duration including a tick in the current cycle, saturating at 31.
  assign dur_inc = (tick && (dur_q != 5'd31)) ? dur_q + 5'd1 : dur_q;

  // 6-bit arithmetic keeps both window bounds free of under/overflow.
  assign dur_ext  = {1'b0, dur_inc};
  assign esp_ext  = {2'b00, duracao_esperada};
  assign tempo_ok = ((dur_ext + TolV) >= esp_ext) && (dur_ext <= (esp_ext + TolV));

  always_comb begin
    estado_d  = estado_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    tocada_d  = tocada_q;
    dur_d     = dur_q;
    correta_d = correta_q;
    tempo_d   = tempo_q;

    if (limpa) begin
      estado_d  = Ocioso;
      cand_d    = '0;
      cnt_d     = '0;
      tocada_d  = '0;
      dur_d     = '0;
      correta_d = 1'b0;
      tempo_d   = 1'b0;
    end else begin
      unique case (estado_q)
        Ocioso: begin
          if (habilita && sinc_oh) begin
            estado_d = Estabiliza;
            cand_d   = sinc_q;
            cnt_d    = CntOne;
          end
        end
        Estabiliza: begin
          if (sinc_q == cand_q) begin
            if (cnt_q >= CntLast) begin
              estado_d  = Pressionada;
              cnt_d     = '0;
              tocada_d  = cand_idx;
              dur_d     = '0;
              correta_d = 1'b0;
              tempo_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end else if (sinc_oh) begin
            cand_d = sinc_q;
            cnt_d  = CntOne;
          end else begin
            estado_d = Ocioso;
            cnt_d    = '0;
          end
        end
        Pressionada: begin
          dur_d = dur_inc;
          if (sinc_q != cand_q) begin
            estado_d = Soltando;
            cnt_d    = CntOne;
          end
        end
        Soltando: begin
          dur_d = dur_inc;
          if (sinc_q == cand_q) begin
            estado_d = Pressionada;
            cnt_d    = '0;
          end else if (cnt_q >= CntLast) begin
            estado_d  = Resultado;
            cnt_d     = '0;
            correta_d = (tocada_q == nota_esperada);
            tempo_d   = tempo_ok;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        Resultado: begin
          // Wait for every key up so a slide or chord cannot start a new press.
          if (sinc_q == 12'd0) estado_d = Ocioso;
        end
        default: begin
          estado_d = Ocioso;
          cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= Ocioso;
      cand_q    <= '0;
      cnt_q     <= '0;
      tocada_q  <= '0;
      dur_q     <= '0;
      correta_q <= 1'b0;
      tempo_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      tocada_q  <= tocada_d;
      dur_q     <= dur_d;
      correta_q <= correta_d;
      tempo_q   <= tempo_d;
    end
  end

  assign nota_feita     = (estado_q == Pressionada) || (estado_q == Soltando);
  assign nota_tocada    = tocada_q;
  assign nota_correta   = correta_q;
  assign tempo_correto  = tempo_q;
  assign duracao_medida = dur_q;
  assign db_estado      = estado_q;

endmodule

// File: tb/tb_modo1_avaliador_nota.sv
// Directed bench for modo1_avaliador_nota with DEBOUNCE=4, TOL=1.
module tb_modo1_avaliador_nota;

  logic        clock = 1'b0;
  logic        reset;
  logic        habilita;
  logic        limpa;
  logic [11:0] teclas;
  logic        tick;
  logic [3:0]  nota_esperada;
  logic [3:0]  duracao_esperada;
  logic        nota_feita;
  logic [3:0]  nota_tocada;
  logic        nota_correta;
  logic        tempo_correto;
  logic [4:0]  duracao_medida;
  logic [2:0]  db_estado;

  int checks   = 0;
  int failures = 0;

  modo1_avaliador_nota #(
    .DEBOUNCE (4),
    .TOL      (1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .habilita         (habilita),
    .limpa            (limpa),
    .teclas           (teclas),
    .tick             (tick),
    .nota_esperada    (nota_esperada),
    .duracao_esperada (duracao_esperada),
    .nota_feita       (nota_feita),
    .nota_tocada      (nota_tocada),
    .nota_correta     (nota_correta),
    .tempo_correto    (tempo_correto),
    .duracao_medida   (duracao_medida),
    .db_estado        (db_estado)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
    end
  endtask

  initial begin
    reset = 1'b0; habilita = 1'b0; limpa = 1'b0; teclas = '0; tick = 1'b0;
    nota_esperada = '0; duracao_esperada = '0;
    step(2);
    reset = 1'b1;
    step(1);
    chk("rst_estado", 8'(db_estado), 8'd0);
    chk("rst_feita", 8'(nota_feita), 8'd0);
    chk("rst_tocada", 8'(nota_tocada), 8'd0);
    chk("rst_dur", 8'(duracao_medida), 8'd0);

    // Clean press of note 3, five ticks, expected 3 / 5.
    habilita = 1'b1; nota_esperada = 4'd3; duracao_esperada = 4'd5;
    teclas = 12'h004;
    step(5);
    chk("t1_feita_pre", 8'(nota_feita), 8'd0);
    chk("t1_estab", 8'(db_estado), 8'd1);
    step(1);
    chk("t1_feita_rise", 8'(nota_feita), 8'd1);
    chk("t1_press", 8'(db_estado), 8'd2);
    chk("t1_tocada", 8'(nota_tocada), 8'd3);
    ticks(5);
    chk("t1_dur_held", 8'(duracao_medida), 8'd5);
    teclas = 12'h000;
    step(5);
    chk("t1_solt_feita", 8'(nota_feita), 8'd1);
    chk("t1_solt", 8'(db_estado), 8'd3);
    step(1);
    chk("t1_res", 8'(db_estado), 8'd4);
    chk("t1_feita_fall", 8'(nota_feita), 8'd0);
    chk("t1_correta", 8'(nota_correta), 8'd1);
    chk("t1_tempo", 8'(tempo_correto), 8'd1);
    chk("t1_dur", 8'(duracao_medida), 8'd5);
    chk("t1_tocada_rel", 8'(nota_tocada), 8'd3);
    step(1);
    chk("t1_idle", 8'(db_estado), 8'd0);
    chk("t1_correta_hold", 8'(nota_correta), 8'd1);

    // Too short for an expected duration of 8.
    duracao_esperada = 4'd8;
    teclas = 12'h004;
    step(6);
    chk("t2_correta_clr", 8'(nota_correta), 8'd0);
    chk("t2_tempo_clr", 8'(tempo_correto), 8'd0);
    ticks(5);
    teclas = 12'h000;
    step(6);
    chk("t2_res", 8'(db_estado), 8'd4);
    chk("t2_tempo", 8'(tempo_correto), 8'd0);
    chk("t2_correta", 8'(nota_correta), 8'd1);
    step(1);

    // Tick on confirm edge ignored, tick on release edge counted; wrong note.
    duracao_esperada = 4'd0; nota_esperada = 4'd5;
    teclas = 12'h004;
    step(5);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("t3_press", 8'(db_estado), 8'd2);
    chk("t3_dur_entry", 8'(duracao_medida), 8'd0);
    teclas = 12'h000;
    step(5);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("t3_res", 8'(db_estado), 8'd4);
    chk("t3_dur", 8'(duracao_medida), 8'd1);
    chk("t3_tempo", 8'(tempo_correto), 8'd1);
    chk("t3_correta", 8'(nota_correta), 8'd0);
    step(1);

    // Release glitch is absorbed; dropping habilita does not abort.
    nota_esperada = 4'd2; duracao_esperada = 4'd4;
    teclas = 12'h002;
    step(6);
    chk("t4_tocada", 8'(nota_tocada), 8'd2);
    ticks(2);
    habilita = 1'b0;
    teclas = 12'h000;
    step(2);
    teclas = 12'h002;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("t4_glitch_feita", 8'(nota_feita), 8'd1);
    end
    chk("t4_back_press", 8'(db_estado), 8'd2);
    chk("t4_dur_mid", 8'(duracao_medida), 8'd2);
    ticks(2);
    chk("t4_dur", 8'(duracao_medida), 8'd4);
    teclas = 12'h000;
    step(6);
    chk("t4_res", 8'(db_estado), 8'd4);
    chk("t4_correta", 8'(nota_correta), 8'd1);
    chk("t4_tempo", 8'(tempo_correto), 8'd1);
    step(1);

    // limpa clears held results.
    limpa = 1'b1;
    step(1);
    limpa = 1'b0;
    chk("t5_clr_correta", 8'(nota_correta), 8'd0);
    chk("t5_clr_tempo", 8'(tempo_correto), 8'd0);
    chk("t5_clr_tocada", 8'(nota_tocada), 8'd0);
    chk("t5_clr_dur", 8'(duracao_medida), 8'd0);

    // Chord with habilita low is ignored, then single key with habilita low.
    teclas = 12'h011;
    step(10);
    chk("t5_chord_estado", 8'(db_estado), 8'd0);
    chk("t5_chord_feita", 8'(nota_feita), 8'd0);
    habilita = 1'b1;
    step(10);
    chk("t5_chord_hab", 8'(db_estado), 8'd0);
    habilita = 1'b0;
    teclas = 12'h004;
    step(10);
    chk("t5_nohab", 8'(db_estado), 8'd0);
    chk("t5_nohab_feita", 8'(nota_feita), 8'd0);
    teclas = 12'h000;
    step(3);
    habilita = 1'b1;

    // limpa while pressed.
    teclas = 12'h008;
    step(6);
    chk("t6_press", 8'(db_estado), 8'd2);
    ticks(2);
    chk("t6_dur", 8'(duracao_medida), 8'd2);
    limpa = 1'b1; habilita = 1'b0; teclas = 12'h000;
    step(1);
    limpa = 1'b0;
    chk("t6_estado", 8'(db_estado), 8'd0);
    chk("t6_feita", 8'(nota_feita), 8'd0);
    chk("t6_tocada", 8'(nota_tocada), 8'd0);
    chk("t6_dur_clr", 8'(duracao_medida), 8'd0);
    step(3);
    chk("t6_idle", 8'(db_estado), 8'd0);
    habilita = 1'b1;

    // Slide from note 11 to note 12 stays in RESULTADO until all keys up.
    nota_esperada = 4'd11; duracao_esperada = 4'd1;
    teclas = 12'h400;
    step(6);
    ticks(1);
    teclas = 12'h800;
    step(6);
    chk("t7_res", 8'(db_estado), 8'd4);
    chk("t7_tocada", 8'(nota_tocada), 8'd11);
    chk("t7_correta", 8'(nota_correta), 8'd1);
    chk("t7_tempo", 8'(tempo_correto), 8'd1);
    step(10);
    chk("t7_hold", 8'(db_estado), 8'd4);
    chk("t7_hold_feita", 8'(nota_feita), 8'd0);
    teclas = 12'h000;
    step(3);
    chk("t7_idle", 8'(db_estado), 8'd0);
    teclas = 12'h800;
    step(6);
    chk("t7_new_press", 8'(db_estado), 8'd2);
    chk("t7_new_tocada", 8'(nota_tocada), 8'd12);
    ticks(1);

    // Asynchronous reset mid-press.
    #2;
    reset = 1'b0;
    #1;
    chk("t8_estado", 8'(db_estado), 8'd0);
    chk("t8_feita", 8'(nota_feita), 8'd0);
    chk("t8_tocada", 8'(nota_tocada), 8'd0);
    chk("t8_dur", 8'(duracao_medida), 8'd0);
    chk("t8_correta", 8'(nota_correta), 8'd0);
    chk("t8_tempo", 8'(tempo_correto), 8'd0);
    teclas = 12'h000;
    #1;
    reset = 1'b1;
    step(3);
    chk("t8_after", 8'(db_estado), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
